// File: rtl/seven_seg_scan.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display.
// A free-running counter picks one digit at a time; all outputs are active-low and registered.
module seven_seg_scan #(
  parameter int REFRESH_BITS = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic [3:0]  data_dp,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an
);

  logic [REFRESH_BITS-1:0] cnt;
  logic [1:0]              sel;
  logic [3:0]              nibble;
  logic [6:0]              seg_d;

  assign sel = cnt[REFRESH_BITS-1 -: 2];

  always_comb begin
    nibble = data_in[3:0];
    case (sel)
      2'd0: nibble = data_in[3:0];
      2'd1: nibble = data_in[7:4];
      2'd2: nibble = data_in[11:8];
      2'd3: nibble = data_in[15:12];
      default: nibble = data_in[3:0];
    endcase
  end

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  always_comb begin
    seg_d = 7'b1111111;
    case (nibble)
      4'h0: seg_d = 7'b1000000;
      4'h1: seg_d = 7'b1111001;
      4'h2: seg_d = 7'b0100100;
      4'h3: seg_d = 7'b0110000;
      4'h4: seg_d = 7'b0011001;
      4'h5: seg_d = 7'b0010010;
      4'h6: seg_d = 7'b0000010;
      4'h7: seg_d = 7'b1111000;
      4'h8: seg_d = 7'b0000000;
      4'h9: seg_d = 7'b0010000;
      4'hA: seg_d = 7'b0001000;
      4'hB: seg_d = 7'b0000011;
      4'hC: seg_d = 7'b1000110;
      4'hD: seg_d = 7'b0100001;
      4'hE: seg_d = 7'b0000110;
      4'hF: seg_d = 7'b0001110;
      default: seg_d = 7'b1111111;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
      an  <= ~(4'b0001 << sel);
      seg <= seg_d;
      dp  <= data_dp[sel];
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with a small scan counter so full scans are short.
module tb_seven_seg_scan;

  localparam int RB     = 4;
  localparam int PERIOD = 1 << RB;
  localparam int HOLD   = 1 << (RB - 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] din = 16'h0000;
  logic [3:0]  ddp = 4'hF;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;

  int passed = 0;
  int total  = 0;
  int edges  = 0;
  logic [6:0] hex_tab [16];

  seven_seg_scan #(.REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst_n), .data_in(din), .data_dp(ddp),
    .seg(seg), .dp(dp), .an(an)
  );

  always #5 clk = ~clk;

  // Edge n (1-based since reset release) shows digit ((n-1) mod PERIOD) / HOLD.
  function automatic int sel_of(int e);
    return ((e - 1) % PERIOD) / HOLD;
  endfunction

  function automatic logic [3:0] exp_an(int e);
    return 4'hF & ~(4'(1) << sel_of(e));
  endfunction

  function automatic logic [6:0] exp_seg(int e, logic [15:0] d);
    int nib;
    nib = (int'(d) >> (4 * sel_of(e))) & 15;
    return hex_tab[nib];
  endfunction

  function automatic logic exp_dp(int e, logic [3:0] p);
    return p[sel_of(e)];
  endfunction

  task automatic tick();
    @(posedge clk);
    edges++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    din = 16'hABCD;
    ddp = 4'h0;
    #1;
    total++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
      $display("FAIL reset_async an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
      $display("FAIL reset_hold an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    else passed++;
  endtask

  task automatic test_scan_order();
    din = 16'h1234;
    ddp = 4'b1110;
    do_reset();
    for (int i = 0; i < 17; i++) begin
      tick();
      total++;
      if (an !== exp_an(edges) || seg !== exp_seg(edges, din) || dp !== exp_dp(edges, ddp))
        $display("FAIL scan_order edge=%0d an=%b seg=%b dp=%b want %b/%b/%b", edges, an, seg, dp,
                 exp_an(edges), exp_seg(edges, din), exp_dp(edges, ddp));
      else passed++;
    end
    total++;
    if (an !== 4'b1110 || edges != 17)
      $display("FAIL scan_wrap an=%b want 1110", an);
    else passed++;
  endtask

  task automatic test_hex_sweep();
    for (int n = 0; n < 16; n++) begin
      while (sel_of(edges + 1) != 0) tick();
      din = {16'($urandom_range(0, 4095)) << 4} | 16'(n);
      ddp = 4'($urandom_range(0, 15));
      tick();
      total++;
      if (an !== 4'b1110 || seg !== hex_tab[n])
        $display("FAIL hex_sweep nib=%h an=%b seg=%b want 1110/%b", n, an, seg, hex_tab[n]);
      else passed++;
    end
  endtask

  task automatic test_dp_walk();
    for (int k = 0; k < 4; k++) begin
      ddp = ~(4'(1) << k);
      for (int i = 0; i < PERIOD; i++) begin
        tick();
        total++;
        if (dp !== (an[k] ? 1'b1 : 1'b0) || an !== exp_an(edges))
          $display("FAIL dp_walk k=%0d an=%b dp=%b want an=%b dp=%b", k, an, dp,
                   exp_an(edges), (sel_of(edges) == k) ? 1'b0 : 1'b1);
        else passed++;
      end
    end
  endtask

  task automatic test_async_mid_scan();
    while (sel_of(edges + 1) != 2) tick();
    tick();
    total++;
    if (an !== 4'b1011)
      $display("FAIL midscan_pre an=%b want 1011", an);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({an, seg, dp} !== {4'b1111, 7'b1111111, 1'b1})
      $display("FAIL midscan_blank an=%b seg=%b dp=%b want 1111/1111111/1", an, seg, dp);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    edges = 0;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== exp_seg(edges, din))
      $display("FAIL midscan_restart an=%b seg=%b want 1110/%b", an, seg, exp_seg(edges, din));
    else passed++;
  endtask

  task automatic test_live_update();
    while (sel_of(edges + 1) != 0) tick();
    din = 16'h0000;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b1000000)
      $display("FAIL live_before an=%b seg=%b want 1110/1000000", an, seg);
    else passed++;
    din = 16'hFFFF;
    tick();
    total++;
    if (an !== 4'b1110 || seg !== 7'b0001110)
      $display("FAIL live_after an=%b seg=%b want 1110/0001110", an, seg);
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      din = 16'($urandom);
      ddp = 4'($urandom);
      tick();
      total++;
      if (an !== exp_an(edges) || seg !== exp_seg(edges, din) || dp !== exp_dp(edges, ddp))
        $display("FAIL random edge=%0d din=%h ddp=%b an=%b seg=%b dp=%b want %b/%b/%b",
                 edges, din, ddp, an, seg, dp,
                 exp_an(edges), exp_seg(edges, din), exp_dp(edges, ddp));
      else passed++;
    end
  endtask

  initial begin
    hex_tab[0]  = 7'b1000000; hex_tab[1]  = 7'b1111001;
    hex_tab[2]  = 7'b0100100; hex_tab[3]  = 7'b0110000;
    hex_tab[4]  = 7'b0011001; hex_tab[5]  = 7'b0010010;
    hex_tab[6]  = 7'b0000010; hex_tab[7]  = 7'b1111000;
    hex_tab[8]  = 7'b0000000; hex_tab[9]  = 7'b0010000;
    hex_tab[10] = 7'b0001000; hex_tab[11] = 7'b0000011;
    hex_tab[12] = 7'b1000110; hex_tab[13] = 7'b0100001;
    hex_tab[14] = 7'b0000110; hex_tab[15] = 7'b0001110;

    test_reset();
    test_scan_order();
    test_hex_sweep();
    test_dp_walk();
    test_async_mid_scan();
    test_live_update();
    test_random();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan.md
Name: seven_seg_scan

Overview:
- Time-multiplexed driver for a 4-digit, common-anode, 7-segment LED display.
- Takes a 16-bit value and shows it as four hex digits, each with its own decimal-point control.
- Scans one digit at a time at a rate set by a free-running counter.
- Sits between the ciphertext word selector and the board display pins; all outputs are active-low.

Parameters:
- REFRESH_BITS, 18, width of the free-running scan counter. Must be >= 3. Each digit is held for 2^(REFRESH_BITS-2) clocks.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- data_in  input  16  value to display; digit0 = [3:0] (rightmost), digit1 = [7:4], digit2 = [11:8], digit3 = [15:12] (leftmost).
- data_dp  input  4  per-digit decimal point, active-low; bit k = 0 lights the dp of digit k.
- seg  output  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a} = seg[6:0].
- dp  output  1  decimal-point cathode, active-low.
- an  output  4  digit anodes, active-low; an[k] = 0 enables digit k.

Behaviour:
- Reset (rst = 0, asynchronous, independent of clk):
  - cnt = 0.
  - an = 4'b1111 (all digits off), seg = 7'b1111111, dp = 1.
  - Outputs hold these values for as long as reset is asserted.
- Scan counter: cnt[REFRESH_BITS-1:0] increments by 1 on every rising clk edge when not in reset; it wraps from all-ones to 0 with no gap or stall.
- Digit select: sel = cnt[REFRESH_BITS-1:REFRESH_BITS-2], giving the order 0,1,2,3,0,...
- Output registers: on each rising edge, using the pre-increment value of cnt:
  - an <= ~(4'b0001 << sel), so exactly one anode is low.
  - seg <= hex decode of nibble sel of data_in.
  - dp <= data_dp[sel].
- Latency: outputs reflect data_in/data_dp sampled at the same edge, one register stage, no further pipelining.
- Input changes mid-digit appear on the next clock edge.
- Hex decode, seg[6:0] = {g..a}, active-low:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- No latches; decode is a full case covering all 16 values.
- After reset, an is never 4'b1111 again.
- Reset asserted mid-scan: outputs blank immediately without a clock. After release, scanning restarts at digit0 on the first rising edge.
- No handshake; data_in and data_dp are treated as level inputs and may change on any cycle.

Test Plan:
- REFRESH_BITS=4, data_in=16'h1234, data_dp=4'b1110; release reset:
  - edges 1-4: an=1110, seg=0011001 ("4"), dp=0.
  - edges 5-8: an=1101, seg=0110000 ("3"), dp=1.
  - edges 9-12: an=1011, seg=0100100 ("2").
  - edges 13-16: an=0111, seg=1111001 ("1").
  - edge 17: an=1110 again (wrap).
- Hex decode sweep: REFRESH_BITS=4, data_in=16'hXXXn for n=0..F, observed while an=1110 -> seg matches every entry of the decode table (e.g. A=0001000, F=0001110).
- Decimal point walk: data_dp stepped through ~4'h1, ~4'h2, ~4'h4, ~4'h8 -> dp=0 only while the matching anode is low, dp=1 on the other three digits.
- Asynchronous reset mid-scan: assert rst low between clock edges while an=1011 -> an=1111, seg=1111111, dp=1 before the next edge. Release -> first edge gives an=1110.
- Live update: change data_in from 16'h0000 to 16'hFFFF in the middle of digit0 -> seg changes from 1000000 to 0001110 on the very next edge, an unchanged.
- Default parameter sanity: REFRESH_BITS=18 -> each digit held exactly 65536 clocks, full scan period 262144 clocks.
